sram_rr_scheduler: RTL and testbench

- Single-clock issue scheduler in the sram_clock domain, between the clock-crossing FIFOs (two write-request, two read-address, two read-data) and the SRAM controller.
- Round-robin arbitration over W0, W1, R0, R1. Issues one registered transaction at a time with valid/ready. Tracks outstanding reads with an in-order tag queue and steers returned data to the correct read-data FIFO.

---
 rtl/sram_sched_pkg.sv | 31 +++
 rtl/sram_tag_fifo.sv | 59 +++++
 rtl/sram_rr_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_sram_rr_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sched_pkg.sv
// Shared constants for the SRAM issue scheduler: port IDs, request field layout and FSM states.
package sram_sched_pkg;

  localparam int ADDR_W_DEF    = 18;
  localparam int DATA_W_DEF    = 32;
  localparam int MASK_W_DEF    = 4;
  localparam int TAG_DEPTH_DEF = 4;

  localparam logic [1:0] PID_W0 = 2'd0;
  localparam logic [1:0] PID_W1 = 2'd1;
  localparam logic [1:0] PID_R0 = 2'd2;
  localparam logic [1:0] PID_R1 = 2'd3;

  // Write request word is {mask, addr, data}, data in the LSBs.
  localparam int REQ_DATA_LSB = 0;
  localparam int REQ_DATA_MSB = DATA_W_DEF - 1;
  localparam int REQ_ADDR_LSB = DATA_W_DEF;
  localparam int REQ_ADDR_MSB = DATA_W_DEF + ADDR_W_DEF - 1;
  localparam int REQ_MASK_LSB = DATA_W_DEF + ADDR_W_DEF;
  localparam int REQ_MASK_MSB = DATA_W_DEF + ADDR_W_DEF + MASK_W_DEF - 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } sched_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sram_tag_fifo.sv
// In-order read tag queue: 1-bit entries (0 = R0, 1 = R1) with simultaneous push/pop.
module sram_tag_fifo
  import sram_sched_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic                     sram_clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_port,
  input  logic                     pop,
  output logic                     head_port,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == CNT_W'(0));
  assign full      = (count_r == CNT_W'(DEPTH));
  assign count     = count_r;
  assign head_port = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  // A pop in the same cycle frees the slot the push writes into.
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      mem_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_port;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_rr_scheduler.sv
// Round-robin issue of W0/W1/R0/R1 to the SRAM controller with in-order read-data steering.
// Optional macro SRAM_SCHED_PERF_EN enables per-port accept counters and a stall counter.
module sram_rr_scheduler
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MASK_W    = MASK_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                            sram_clock,
  input  logic                            reset,
  input  logic                            w0_req_valid,
  input  logic                            w1_req_valid,
  input  logic [MASK_W+ADDR_W+DATA_W-1:0] w0_req,
  input  logic [MASK_W+ADDR_W+DATA_W-1:0] w1_req,
  output logic                            w0_req_pop,
  output logic                            w1_req_pop,
  input  logic                            r0_addr_valid,
  input  logic                            r1_addr_valid,
  input  logic [ADDR_W-1:0]               r0_addr,
  input  logic [ADDR_W-1:0]               r1_addr,
  output logic                            r0_addr_pop,
  output logic                            r1_addr_pop,
  input  logic                            r0_data_afull,
  input  logic                            r1_data_afull,
  output logic                            r0_data_push,
  output logic                            r1_data_push,
  output logic [DATA_W-1:0]               r0_data,
  output logic [DATA_W-1:0]               r1_data,
  output logic                            sram_addr_valid,
  input  logic                            sram_ready,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic [DATA_W-1:0]               sram_data_in,
  output logic [MASK_W-1:0]               sram_write_mask,
  input  logic [DATA_W-1:0]               sram_data_out,
  input  logic                            sram_data_out_valid,
  output logic                            tag_err,
  output logic [4*16-1:0]                 perf_cnt,
  output logic [15:0]                     perf_stall
);

  localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

  sched_state_t      state_r;
  sched_state_t      state_nxt_s;
  logic [1:0]        last_grant_r;
  logic [1:0]        issue_id_r;
  logic [1:0]        grant_id_s;
  logic              grant_s;
  logic              load_s;
  logic              accept_s;
  logic              pending_read_s;
  logic              reads_free_s;
  logic [3:0]        elig_s;
  logic [ADDR_W-1:0] sram_addr_r;
  logic [DATA_W-1:0] sram_data_in_r;
  logic [MASK_W-1:0] sram_write_mask_r;
  logic [ADDR_W-1:0] txn_addr_s;
  logic [DATA_W-1:0] txn_data_s;
  logic [MASK_W-1:0] txn_mask_s;
  logic [CNT_W-1:0]  tag_count_s;
  logic [CNT_W-1:0]  reads_inflight_s;
  logic              tag_full_s;
  logic              tag_empty_s;
  logic              tag_head_s;
  logic              tag_push_s;
  logic              tag_pop_s;
  logic              tag_err_r;

  assign load_s   = (state_r == ST_IDLE) || sram_ready;
  assign accept_s = (state_r == ST_ISSUE) && sram_ready;

  // A read sitting in the issue register already owns a tag slot, so it is counted as in flight.
  assign pending_read_s   = (state_r == ST_ISSUE) && issue_id_r[1];
  assign reads_inflight_s = tag_count_s + CNT_W'(pending_read_s);
  assign reads_free_s     = !tag_full_s && (reads_inflight_s < CNT_W'(TAG_DEPTH));

  // Qualify requesters and pick the first eligible one after last_grant_r on the ring.
  always_comb begin
    logic [1:0] cand_s;
    logic       hit_s;
    grant_s    = 1'b0;
    grant_id_s = last_grant_r;
    cand_s     = last_grant_r;
    hit_s      = 1'b0;
    if (load_s && !reset) begin
      elig_s = {r1_addr_valid && !r1_data_afull && reads_free_s,
                r0_addr_valid && !r0_data_afull && reads_free_s,
                w1_req_valid, w0_req_valid};
    end else begin
      elig_s = 4'b0000;
    end
    for (int k = 1; k <= 4; k++) begin
      cand_s     = last_grant_r + 2'(k);
      hit_s      = elig_s[cand_s] && !grant_s;
      grant_id_s = hit_s ? cand_s : grant_id_s;
      grant_s    = grant_s || hit_s;
    end
  end

  assign w0_req_pop  = grant_s && (grant_id_s == PID_W0);
  assign w1_req_pop  = grant_s && (grant_id_s == PID_W1);
  assign r0_addr_pop = grant_s && (grant_id_s == PID_R0);
  assign r1_addr_pop = grant_s && (grant_id_s == PID_R1);

  // Transaction fields for the granted port; reads carry zero mask and data.
  always_comb begin
    txn_addr_s = '0;
    txn_data_s = '0;
    txn_mask_s = '0;
    case (grant_id_s)
      PID_W0: begin
        txn_mask_s = w0_req[DATA_W+ADDR_W +: MASK_W];
        txn_addr_s = w0_req[DATA_W +: ADDR_W];
        txn_data_s = w0_req[0 +: DATA_W];
      end
      PID_W1: begin
        txn_mask_s = w1_req[DATA_W+ADDR_W +: MASK_W];
        txn_addr_s = w1_req[DATA_W +: ADDR_W];
        txn_data_s = w1_req[0 +: DATA_W];
      end
      PID_R0:  txn_addr_s = r0_addr;
      PID_R1:  txn_addr_s = r1_addr;
      default: txn_addr_s = '0;
    endcase
  end

  // Next-state logic: stay in ISSUE while the controller stalls.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = grant_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        if (sram_ready) begin
          state_nxt_s = grant_s ? ST_ISSUE : ST_IDLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Issue register: load on grant, clear on an empty load, otherwise hold stable.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      last_grant_r      <= PID_R1;
      issue_id_r        <= PID_W0;
      sram_addr_r       <= '0;
      sram_data_in_r    <= '0;
      sram_write_mask_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        last_grant_r      <= grant_id_s;
        issue_id_r        <= grant_id_s;
        sram_addr_r       <= txn_addr_s;
        sram_data_in_r    <= txn_data_s;
        sram_write_mask_r <= txn_mask_s;
      end else if (load_s) begin
        sram_addr_r       <= '0;
        sram_data_in_r    <= '0;
        sram_write_mask_r <= '0;
      end
    end
  end

  assign sram_addr_valid = (state_r == ST_ISSUE);
  assign sram_addr       = sram_addr_r;
  assign sram_data_in    = sram_data_in_r;
  assign sram_write_mask = sram_write_mask_r;

  assign tag_push_s = accept_s && issue_id_r[1] && !reset;
  assign tag_pop_s  = sram_data_out_valid && !tag_empty_s && !reset;

  sram_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .sram_clock (sram_clock),
    .reset      (reset),
    .push       (tag_push_s),
    .push_port  (issue_id_r[0]),
    .pop        (tag_pop_s),
    .head_port  (tag_head_s),
    .empty      (tag_empty_s),
    .full       (tag_full_s),
    .count      (tag_count_s)
  );

  assign r0_data_push = tag_pop_s && !tag_head_s;
  assign r1_data_push = tag_pop_s && tag_head_s;
  assign r0_data      = r0_data_push ? sram_data_out : '0;
  assign r1_data      = r1_data_push ? sram_data_out : '0;

  // Sticky flag for data returned with no read outstanding.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      tag_err_r <= 1'b0;
    end else if (sram_data_out_valid && tag_empty_s) begin
      tag_err_r <= 1'b1;
    end
  end

  assign tag_err = tag_err_r;

`ifdef SRAM_SCHED_PERF_EN
  logic [4*16-1:0] perf_cnt_r;
  logic [15:0]     perf_stall_r;

  // Saturating accepted-transaction counters per port and stall-cycle counter.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      perf_cnt_r   <= '0;
      perf_stall_r <= '0;
    end else begin
      if (accept_s) begin
        perf_cnt_r[{issue_id_r, 4'b0000} +: 16] <= sat_inc16(perf_cnt_r[{issue_id_r, 4'b0000} +: 16]);
      end
      if ((state_r == ST_ISSUE) && !sram_ready) begin
        perf_stall_r <= sat_inc16(perf_stall_r);
      end
    end
  end

  assign perf_cnt   = perf_cnt_r;
  assign perf_stall = perf_stall_r;
`else
  assign perf_cnt   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_sram_rr_scheduler.sv
// Randomized scoreboard bench for sram_rr_scheduler against a transaction-level reference model.
module tb_sram_rr_scheduler;
  import sram_sched_pkg::*;

  localparam int AW = 18;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TD = 4;
  localparam int RW = MW + AW + DW;

  logic          sram_clock = 1'b0;
  logic          reset = 1'b1;
  logic          w0_req_valid = 1'b0, w1_req_valid = 1'b0;
  logic [RW-1:0] w0_req = '0, w1_req = '0;
  logic          w0_req_pop, w1_req_pop;
  logic          r0_addr_valid = 1'b0, r1_addr_valid = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic          r0_addr_pop, r1_addr_pop;
  logic          r0_data_afull = 1'b0, r1_data_afull = 1'b0;
  logic          r0_data_push, r1_data_push;
  logic [DW-1:0] r0_data, r1_data;
  logic          sram_addr_valid;
  logic          sram_ready = 1'b0;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_in;
  logic [MW-1:0] sram_write_mask;
  logic [DW-1:0] sram_data_out = '0;
  logic          sram_data_out_valid = 1'b0;
  logic          tag_err;
  logic [63:0]   perf_cnt;
  logic [15:0]   perf_stall;

  always #5 sram_clock = ~sram_clock;

  sram_rr_scheduler dut (
    .sram_clock(sram_clock), .reset(reset),
    .w0_req_valid(w0_req_valid), .w1_req_valid(w1_req_valid),
    .w0_req(w0_req), .w1_req(w1_req), .w0_req_pop(w0_req_pop), .w1_req_pop(w1_req_pop),
    .r0_addr_valid(r0_addr_valid), .r1_addr_valid(r1_addr_valid),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_addr_pop(r0_addr_pop), .r1_addr_pop(r1_addr_pop),
    .r0_data_afull(r0_data_afull), .r1_data_afull(r1_data_afull),
    .r0_data_push(r0_data_push), .r1_data_push(r1_data_push),
    .r0_data(r0_data), .r1_data(r1_data),
    .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready), .sram_addr(sram_addr),
    .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
    .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
    .tag_err(tag_err), .perf_cnt(perf_cnt), .perf_stall(perf_stall)
  );

  // Bench-side FIFOs (first-word-fall-through) per requester; reads stored as {0, addr, 0}.
  logic [RW-1:0] q0[$], q1[$], q2[$], q3[$];
  logic [RW-1:0] exp_txn[$];
  logic [DW:0]   exp_ret[$];
  int            acc_q[$];
  logic [DW-1:0] fdata[$];

  int   errors = 0, checks = 0;
  int   ready_pct = 100, afull_pct = 0, ret_pct = 0, n_acc_rd = 0;
  logic force_ret = 1'b0, mon_en = 1'b0;
  logic [3:0] pend_pop = 4'b0000;

  // Reference model: reads in flight count from grant until their data returns.
  int            m_last, m_res, m_cur;
  logic          m_busy, m_tag_err;
  logic [RW-1:0] m_txn;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [RW-1:0] qhead(input int p);
    if (qsize(p) == 0) return '0;
    case (p)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic qpush(input int p, input logic [RW-1:0] v);
    case (p)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic qpop(input int p);
    case (p)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  function automatic logic [RW-1:0] mkread(input logic [AW-1:0] a);
    return {4'b0000, a, 32'h0000_0000};
  endfunction

  function automatic logic [RW-1:0] mkreq(input int p);
    if (p < 2) return {MW'($urandom_range(1, 15)), AW'($urandom), DW'($urandom)};
    return mkread(AW'($urandom));
  endfunction

  task automatic step();
    logic [3:0]    elig, exp_pop;
    logic [RW-1:0] h;
    logic          load, found, ret_free;
    int            gp, p;
    @(negedge sram_clock);
    for (int i = 0; i < 4; i++) if (pend_pop[i]) qpop(i);
    pend_pop = 4'b0000;
    w0_req_valid = qsize(0) > 0;  w0_req = qhead(0);
    w1_req_valid = qsize(1) > 0;  w1_req = qhead(1);
    h = qhead(2); r0_addr_valid = qsize(2) > 0; r0_addr = h[REQ_ADDR_LSB +: AW];
    h = qhead(3); r1_addr_valid = qsize(3) > 0; r1_addr = h[REQ_ADDR_LSB +: AW];
    sram_ready    = $urandom_range(0, 99) < ready_pct;
    r0_data_afull = $urandom_range(0, 99) < afull_pct;
    r1_data_afull = $urandom_range(0, 99) < afull_pct;
    sram_data_out_valid = force_ret || (acc_q.size() > 0 && $urandom_range(0, 99) < ret_pct);
    sram_data_out = (sram_data_out_valid && fdata.size() > 0) ? fdata.pop_front() : DW'($urandom);
    #1;
    check("tag_err", {63'd0, tag_err}, {63'd0, m_tag_err});
    check("addr_valid", {63'd0, sram_addr_valid}, {63'd0, m_busy});
    if (m_busy) check("held_txn", {10'd0, sram_write_mask, sram_addr, sram_data_in}, {10'd0, m_txn});
    ret_free = 1'b0;
    if (sram_data_out_valid) begin
      if (acc_q.size() > 0) begin
        p = acc_q.pop_front();
        exp_ret.push_back({p[0], sram_data_out});
        ret_free = 1'b1;
      end else begin
        m_tag_err = 1'b1;
      end
    end
    if (m_busy && sram_ready && m_cur >= 2) acc_q.push_back(m_cur - 2);
    load = !m_busy || sram_ready;
    elig = {qsize(3) > 0 && !r1_data_afull && m_res < TD,
            qsize(2) > 0 && !r0_data_afull && m_res < TD,
            qsize(1) > 0, qsize(0) > 0};
    found = 1'b0; gp = 0;
    if (load) begin
      for (int k = 1; k <= 4; k++) begin
        p = (m_last + k) % 4;
        if (!found && elig[p]) begin found = 1'b1; gp = p; end
      end
    end
    exp_pop = found ? (4'b0001 << gp) : 4'b0000;
    check("pops", {60'd0, r1_addr_pop, r0_addr_pop, w1_req_pop, w0_req_pop}, {60'd0, exp_pop});
    if (found) begin
      m_txn = qhead(gp);
      exp_txn.push_back(m_txn);
      pend_pop[gp] = 1'b1;
      m_last = gp; m_busy = 1'b1; m_cur = gp;
      if (gp >= 2) m_res++;
    end else if (load) begin
      m_busy = 1'b0;
    end
    if (ret_free) m_res--;
  endtask

  // Scoreboard monitor: compares every accepted transaction and every read-data push.
  initial begin
    logic [RW-1:0] t;
    logic [DW:0]   e;
    forever begin
      @(negedge sram_clock);
      #2;
      if (mon_en) begin
        if (sram_addr_valid && sram_ready) begin
          if (exp_txn.size() == 0) begin
            checks++; errors++;
            $display("FAIL accept_unexpected: got addr %h expected none", sram_addr);
          end else begin
            t = exp_txn.pop_front();
            check("accept_txn", {10'd0, sram_write_mask, sram_addr, sram_data_in}, {10'd0, t});
            if (t[REQ_MASK_LSB +: MW] == 4'b0000) n_acc_rd++;
          end
        end
        if (r0_data_push || r1_data_push) begin
          if (exp_ret.size() == 0) begin
            checks++; errors++;
            $display("FAIL push_unexpected: got push %b%b expected none", r1_data_push, r0_data_push);
          end else begin
            e = exp_ret.pop_front();
            check("ret_port", {62'd0, r1_data_push, r0_data_push}, e[DW] ? 64'd2 : 64'd1);
            check("ret_data", {32'd0, e[DW] ? r1_data : r0_data}, {32'd0, e[DW-1:0]});
            check("ret_other", {32'd0, e[DW] ? r0_data : r1_data}, 64'd0);
          end
        end
        if (exp_ret.size() != 0) begin
          checks++; errors++;
          $display("FAIL push_missing: got no push expected %0d", exp_ret.size());
          exp_ret.delete();
        end
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge sram_clock);
    reset = 1'b1;
    w0_req_valid = 1'b0; w1_req_valid = 1'b0; r0_addr_valid = 1'b0; r1_addr_valid = 1'b0;
    sram_ready = 1'b0; sram_data_out_valid = 1'b0; force_ret = 1'b0;
    r0_data_afull = 1'b0; r1_data_afull = 1'b0;
    repeat (2) @(negedge sram_clock);
    check("reset_outputs",
          {sram_addr_valid, w0_req_pop, w1_req_pop, r0_addr_pop, r1_addr_pop,
           r0_data_push, r1_data_push, tag_err, 4'd0, sram_write_mask, 16'd0, 18'(sram_addr)},
          64'd0);
    check("reset_data", {sram_data_in, r0_data | r1_data}, 64'd0);
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    exp_txn.delete(); exp_ret.delete(); acc_q.delete(); fdata.delete();
    pend_pop = 4'b0000;
    m_last = 3; m_res = 0; m_cur = 0; m_busy = 1'b0; m_tag_err = 1'b0; m_txn = '0;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    logic done;
    ready_pct = 100; afull_pct = 0; ret_pct = 100;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0) && !m_busy && m_res == 0 &&
             acc_q.size() == 0 && pend_pop == 4'b0000;
    end
    check("drain", {63'd0, done}, 64'd1);
    ret_pct = 0;
  endtask

  initial begin
    do_reset();

    // W0 write held for four cycles while the controller stalls.
    ready_pct = 0;
    qpush(0, {4'hF, 18'h00010, 32'hDEADBEEF});
    repeat (4) step();
    ready_pct = 100;
    repeat (2) step();

    // Five R0 reads with no returns: only TAG_DEPTH issue until a datum returns.
    n_acc_rd = 0;
    for (int a = 1; a <= 5; a++) qpush(2, mkread(AW'(a)));
    repeat (15) step();
    check("reads_capped", 64'(n_acc_rd), 64'd4);
    fdata.push_back(32'h0000_0011);
    ret_pct = 100;
    step();
    ret_pct = 0;
    repeat (5) step();
    check("reads_resume", 64'(n_acc_rd), 64'd5);
    drain();

    // R1 then R0 with returns A and B steered in issue order.
    qpush(3, mkread(18'h00007));
    step();
    qpush(2, mkread(18'h00009));
    repeat (2) step();
    fdata.push_back(32'h0000_000A);
    fdata.push_back(32'h0000_000B);
    ret_pct = 100;
    repeat (4) step();
    drain();

    // All four requesters busy with the controller always ready.
    for (int p = 0; p < 4; p++) for (int j = 0; j < 3; j++) qpush(p, mkreq(p));
    repeat (20) step();
    drain();

    // Randomized traffic, stalls, afull and returns.
    ready_pct = 70; afull_pct = 20; ret_pct = 40;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 99) < 35) begin
        int p;
        p = $urandom_range(0, 3);
        if (qsize(p) < 6) qpush(p, mkreq(p));
      end
      step();
    end
    drain();

    // Return with no read outstanding sets a sticky tag_err cleared only by reset.
    force_ret = 1'b1;
    step();
    force_ret = 1'b0;
    repeat (3) step();
    check("tag_err_sticky", {63'd0, tag_err}, 64'd1);
    do_reset();
    for (int p = 0; p < 4; p++) qpush(p, mkreq(p));
    repeat (8) step();
    check("perf_default", {perf_cnt[47:0], perf_stall}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
